// File: rtl/clk_ratio_meter.sv
// clk_ratio_meter
// Measures the rise-to-rise period and the high time of a slow periodic input
// in clk cycles, pulses valid on every completed measurement, raises lock once
// LOCK_COUNT consecutive periods agree and flags timeout when no rising edge
// arrives within MAX_RATIO cycles.
//
// Build option: define CLK_RATIO_METER_SYNC_EN to put a 2-flop synchronizer
// in front of the edge detector (for asynchronous sig_in). Without it the input
// is registered once and must be synchronous to clk; latency is one cycle less.
module clk_ratio_meter #(
  parameter  int MAX_RATIO  = 256,
  parameter  int LOCK_COUNT = 4,
  localparam int NBITS      = $clog2(MAX_RATIO + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sig_in,
  output logic [NBITS-1:0] period,
  output logic [NBITS-1:0] high_time,
  output logic             valid,
  output logic             lock,
  output logic             timeout
);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam logic [NBITS-1:0] CNT_LAST = NBITS'(MAX_RATIO - 1);
  localparam logic [MW-1:0]    MATCH_MAX = MW'(LOCK_COUNT);

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    TMO
  } state_t;

  state_t           state;
  logic [NBITS-1:0] cnt;
  logic [NBITS-1:0] cnt_inc;
  logic [NBITS-1:0] hi_cap;
  logic [MW-1:0]    match;
  logic [MW-1:0]    match_next;
  logic             s_p1;
  logic             s_d_p2;
  logic             rise;
  logic             fall;

  // Saturating increment of the agreement counter; it never exceeds LOCK_COUNT.
  function automatic logic [MW-1:0] sat_inc(input logic [MW-1:0] m);
    if (m >= MATCH_MAX) return MATCH_MAX;
    return m + MW'(1);
  endfunction

  // ---- stage p0/p1: input capture ----
`ifdef CLK_RATIO_METER_SYNC_EN
  logic sync_p0;

  // Two-flop synchronizer: sig_in -> sync_p0 -> s_p1.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      s_p1    <= 1'b0;
    end else begin
      sync_p0 <= sig_in;
      s_p1    <= sync_p0;
    end
  end
`else
  // Single input register for a clk-synchronous sig_in.
  always_ff @(posedge clk) begin
    if (reset) s_p1 <= 1'b0;
    else       s_p1 <= sig_in;
  end
`endif

  // ---- stage p2: edge detection ----
  // Delayed copy of the conditioned input for edge detection.
  always_ff @(posedge clk) begin
    if (reset) s_d_p2 <= 1'b0;
    else       s_d_p2 <= s_p1;
  end

  assign rise    = s_p1 & ~s_d_p2;
  assign fall    = ~s_p1 & s_d_p2;
  assign cnt_inc = cnt + NBITS'(1);

  // Next agreement count if a measurement completes this cycle; a zero count
  // marks the first measurement after IDLE or TIMEOUT.
  always_comb begin
    match_next = MW'(1);
    if ((match != '0) && (cnt_inc == period)) match_next = sat_inc(match);
  end

  // ---- measurement FSM, counters and registered outputs ----
  // Counts cycles between accepted rises, captures results, tracks lock/timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      hi_cap    <= '0;
      match     <= '0;
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      lock      <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (rise) state <= MEASURE;
        end
        MEASURE: begin
          if (fall) hi_cap <= cnt_inc;
          // A rise on the last counted cycle still completes a MAX_RATIO period.
          if (rise) begin
            period    <= cnt_inc;
            high_time <= hi_cap;
            valid     <= 1'b1;
            cnt       <= '0;
            match     <= match_next;
            lock      <= (match_next >= MATCH_MAX);
          end else if (cnt == CNT_LAST) begin
            state   <= TMO;
            timeout <= 1'b1;
            lock    <= 1'b0;
            match   <= '0;
            cnt     <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        TMO: begin
          cnt <= '0;
          // The rise that ends a timeout only re-arms; it yields no valid.
          if (rise) begin
            state   <= MEASURE;
            timeout <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clk_ratio_meter.sv
// Testbench for clk_ratio_meter: directed scenarios followed by random square
// waves, every cycle compared against a timestamp-based reference model.
module tb_clk_ratio_meter;

  localparam int MAX_RATIO  = 256;
  localparam int LOCK_COUNT = 4;
  localparam int NB         = $clog2(MAX_RATIO + 1);
`ifdef CLK_RATIO_METER_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk;
  logic          reset;
  logic          sig_in;
  logic [NB-1:0] period;
  logic [NB-1:0] high_time;
  logic          valid;
  logic          lock;
  logic          timeout;

  int errors = 0;
  int checks = 0;

  clk_ratio_meter #(
    .MAX_RATIO (MAX_RATIO),
    .LOCK_COUNT(LOCK_COUNT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .sig_in   (sig_in),
    .period   (period),
    .high_time(high_time),
    .valid    (valid),
    .lock     (lock),
    .timeout  (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: edge index, sample history since reset,
  // timestamps of the last accepted rise, and the list of measured periods.
  bit hist[$];
  int plist[$];
  int n_edge = 0;
  int t_last = 0;
  bit m_armed = 0;
  bit m_valid = 0;
  bit m_lock = 0;
  bit m_tmo = 0;
  int m_period = 0;
  int m_high = 0;
  int m_hi = 0;

  function automatic bit h(input int k);
    if (k < hist.size()) return hist[hist.size() - 1 - k];
    return 1'b0;
  endfunction

  // Locked when the last LOCK_COUNT periods since arming are all equal.
  function automatic bit locked();
    if (plist.size() < LOCK_COUNT) return 1'b0;
    for (int i = plist.size() - LOCK_COUNT; i < plist.size(); i++)
      if (plist[i] != plist[plist.size() - 1]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_edge(input bit sig, input bit rst_v);
    bit rise, fall;
    n_edge++;
    m_valid = 1'b0;
    if (rst_v) begin
      hist.delete();
      plist.delete();
      m_armed = 0; m_lock = 0; m_tmo = 0;
      m_period = 0; m_high = 0; m_hi = 0;
      return;
    end
    rise = h(LAT - 1) & ~h(LAT);
    fall = ~h(LAT - 1) & h(LAT);
    if (!m_armed) begin
      if (rise) begin
        m_armed = 1; m_tmo = 0; t_last = n_edge;
      end
    end else begin
      if (fall) m_hi = n_edge - t_last;
      if (rise) begin
        m_period = n_edge - t_last;
        m_high   = m_hi;
        m_valid  = 1'b1;
        plist.push_back(m_period);
        m_lock   = locked();
        t_last   = n_edge;
      end else if (n_edge - t_last == MAX_RATIO) begin
        m_armed = 0; m_tmo = 1; m_lock = 0;
        plist.delete();
      end
    end
    hist.push_back(sig);
    if (hist.size() > 4) void'(hist.pop_front());
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s at edge %0d: observed=%0d required=%0d", tag, n_edge, obs, req);
    end
  endtask

  // One clk cycle: advance the model at the rising edge, compare at the falling edge.
  task automatic tick();
    @(posedge clk);
    model_edge(sig_in, reset);
    @(negedge clk);
    check("period", 32'(period), 32'(m_period));
    check("high_time", 32'(high_time), 32'(m_high));
    check("valid", 32'(valid), 32'(m_valid));
    check("lock", 32'(lock), 32'(m_lock));
    check("timeout", 32'(timeout), 32'(m_tmo));
  endtask

  task automatic hold(input bit v, input int cycles);
    sig_in = v;
    for (int i = 0; i < cycles; i++) tick();
  endtask

  task automatic wave(input int hi, input int lo, input int reps);
    for (int r = 0; r < reps; r++) begin
      hold(1'b1, hi);
      hold(1'b0, lo);
    end
  endtask

  initial begin
    reset  = 1'b1;
    sig_in = 1'b0;
    tick();
    tick();
    check("rst_period", 32'(period), 0);
    check("rst_lock", 32'(lock), 0);
    check("rst_timeout", 32'(timeout), 0);
    reset = 1'b0;
    hold(1'b0, 3);

    // 50% square wave of period 32
    wave(16, 16, 6);
    check("sq32_period", 32'(period), 32);
    check("sq32_high", 32'(high_time), 16);
    check("sq32_lock", 32'(lock), 1);

    // switch to period 20 while locked
    wave(10, 10, 5);
    check("sq20_period", 32'(period), 20);
    check("sq20_high", 32'(high_time), 10);
    check("sq20_lock", 32'(lock), 1);

    // input stops: timeout and loss of lock
    hold(1'b0, 300);
    check("tmo_flag", 32'(timeout), 1);
    check("tmo_lock", 32'(lock), 0);
    wave(4, 6, 3);
    check("rearm_timeout", 32'(timeout), 0);
    check("rearm_period", 32'(period), 10);
    check("rearm_high", 32'(high_time), 4);

    // rises exactly MAX_RATIO apart, then MAX_RATIO+1 apart
    wave(1, 255, 3);
    check("max_period", 32'(period), 256);
    check("max_high", 32'(high_time), 1);
    check("max_timeout", 32'(timeout), 0);
    wave(1, 256, 2);
    hold(1'b0, 5);
    check("over_timeout", 32'(timeout), 1);
    check("over_period", 32'(period), 256);

    // reset mid-measurement while locked
    wave(8, 8, 6);
    check("pre_rst_lock", 32'(lock), 1);
    hold(1'b1, 3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_period", 32'(period), 0);
    check("mid_rst_high", 32'(high_time), 0);
    check("mid_rst_lock", 32'(lock), 0);
    check("mid_rst_valid", 32'(valid), 0);
    hold(1'b1, 5);
    hold(1'b0, 8);
    wave(8, 8, 3);

    // random square waves, with occasional stalls and resets
    for (int seg = 0; seg < 24; seg++) begin
      int hi, lo, reps;
      hi   = $urandom_range(1, 40);
      lo   = $urandom_range(1, 40);
      reps = $urandom_range(1, 6);
      wave(hi, lo, reps);
      if ($urandom_range(0, 7) == 0) hold(1'b0, $urandom_range(200, 280));
      if ($urandom_range(0, 9) == 0) begin
        sig_in = 1'($urandom_range(0, 1));
        reset  = 1'b1;
        tick();
        reset  = 1'b0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
